// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: drives the PLL reset, waits for a stable lock,
// holds the downstream system reset for a fixed time, and then runs. On a
// loss of lock it returns to PLL_RST. After MAX_RETRY failed attempts it
// stops in FAIL, and only rst can take it out of FAIL.
module clk_rst_seq #(
  parameter int PLL_RST_LEN     = 16,
  parameter int LOCK_STABLE_LEN = 1024,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int SYS_RST_LEN     = 16,
  parameter int MAX_RETRY       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       ready,
  output logic       err,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  localparam int PR_W = $clog2(PLL_RST_LEN + 1);
  localparam int ST_W = $clog2(LOCK_STABLE_LEN + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int SR_W = $clog2(SYS_RST_LEN + 1);

  // Each counter starts at 0 when its state is entered. A state ends on the
  // cycle where its counter holds LEN-1, which gives exactly LEN cycles in
  // that state.
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_LEN - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE_LEN - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SR_W-1:0] SR_LAST = SR_W'(SYS_RST_LEN - 1);
  localparam logic [7:0]      RETRY_LIMIT = 8'(MAX_RETRY);

  logic [2:0]      state, state_nxt;
  logic [PR_W-1:0] prst_cnt;
  logic [ST_W-1:0] stable_cnt;
  logic [TO_W-1:0] tmo_cnt;
  logic [SR_W-1:0] srst_cnt;
  logic            sync_1, locked_s;
  logic            retry_inc, loss_ev;
  logic [7:0]      retry_nxt;

  assign state_dbg = state;
  assign retry_nxt = retry_cnt + 8'd1;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_1   <= pll_locked;
      locked_s <= sync_1;
    end
  end

  // Next-state decode. In WAIT_LOCK the lock check comes before the
  // timeout check, so lock acceptance wins when both happen on one cycle.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    loss_ev   = 1'b0;
    case (state)
      S_PLL_RST: begin
        if (prst_cnt == PR_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s && (stable_cnt == ST_LAST)) begin
          state_nxt = S_RELEASE;
        end else if (tmo_cnt == TO_LAST) begin
          retry_inc = 1'b1;
          state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAIL : S_PLL_RST;
        end
      end
      S_RELEASE: begin
        if (!locked_s) begin
          loss_ev   = 1'b1;
          state_nxt = S_PLL_RST;
        end else if (srst_cnt == SR_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          loss_ev   = 1'b1;
          state_nxt = S_PLL_RST;
        end
      end
      S_FAIL:  state_nxt = S_FAIL;
      default: state_nxt = S_PLL_RST;
    endcase
  end

  // Per-state counters. All of them clear on any state change and on rst.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state)) begin
      prst_cnt   <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      srst_cnt   <= '0;
    end else begin
      case (state)
        S_PLL_RST: prst_cnt <= prst_cnt + 1'b1;
        S_WAIT_LOCK: begin
          tmo_cnt    <= tmo_cnt + 1'b1;
          stable_cnt <= locked_s ? stable_cnt + 1'b1 : '0;
        end
        S_RELEASE: srst_cnt <= srst_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // State register and registered outputs. The outputs are decoded from
  // the next state, so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      pll_rst   <= 1'b1;
      rst_out   <= 1'b1;
      ready     <= 1'b0;
      err       <= 1'b0;
      retry_cnt <= 8'd0;
      loss_cnt  <= 8'd0;
    end else begin
      state   <= state_nxt;
      pll_rst <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAIL);
      rst_out <= (state_nxt != S_RUN);
      ready   <= (state_nxt == S_RUN);
      err     <= (state_nxt == S_FAIL);
      if (retry_inc) begin
        retry_cnt <= retry_nxt;
      end else if ((state_nxt == S_RUN) && (state != S_RUN)) begin
        retry_cnt <= 8'd0;
      end
      if (loss_ev && (loss_cnt != 8'hFF)) loss_cnt <= loss_cnt + 8'd1;
    end
  end

endmodule
